// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: reset PC and inter-stage bus layouts so every
// stage agrees on field positions.
package pipe_pkg;

    localparam logic [31:0] RESET_PC    = 32'h1c000000;
    localparam int          IF_ID_BUS_W = 64;
    localparam int          ID_EX_BUS_W = 117;

    // {inst, pc} field offsets inside the IF->ID bundle
    localparam int IF_ID_PC_LSB   = 0;
    localparam int IF_ID_INST_LSB = 32;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } if_id_bus_t;

    function automatic logic [IF_ID_BUS_W-1:0] pack_if_id(input logic [31:0] inst,
                                                          input logic [31:0] pc);
        if_id_bus_t b;
        b.inst = inst;
        b.pc   = pc;
        return b;
    endfunction

endpackage

// File: rtl/if_inst_buf.sv
// Small circular FIFO holding fetched {inst, pc} bundles while ID stalls.
// Flush wins over push and pop; storage is cleared only by reset.
module if_inst_buf #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2,
    parameter int PTR_W  = $clog2(DEPTH),
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [CNT_W-1:0]  count,
    output logic [DATA_W-1:0] head_data
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    // DEPTH is a power of two, so pointers wrap naturally
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/stage_1_if.sv
// Instruction-fetch stage: drives the synchronous instruction SRAM, buffers
// responses and hands {inst, pc} to ID, applying redirects from ID.
module stage_1_if #(
    parameter logic [31:0] RESET_PC  = pipe_pkg::RESET_PC,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata,
    output logic        valid_1,
    input  logic        allow_2,
    output logic [63:0] stage_1_to_2,
    input  logic        br_taken,
    input  logic [31:0] br_target
);
    import pipe_pkg::*;

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;

    logic [31:0]            fetch_pc;
    logic [31:0]            pend_pc;
    logic                   pend;
    logic [CNT_W-1:0]       count;
    logic [IF_ID_BUS_W-1:0] head_data;
    logic                   pop;
    logic                   push;
    logic [OCC_W-1:0]       occ;

    assign valid_1 = (count != '0) && !br_taken;
    assign pop     = valid_1 && allow_2;
    assign push    = pend && !br_taken;

    // Slots committed after this cycle: buffered + in flight - leaving now
    assign occ = OCC_W'(count) + OCC_W'(pend) - OCC_W'(pop);

    assign inst_sram_en    = !reset && (br_taken || (occ < OCC_W'(BUF_DEPTH)));
    assign inst_sram_addr  = br_taken ? br_target : fetch_pc;
    assign inst_sram_we    = 4'b0;
    assign inst_sram_wdata = 32'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            pend     <= 1'b0;
        end else if (inst_sram_en) begin
            fetch_pc <= inst_sram_addr + 32'd4;
            pend     <= 1'b1;
        end else begin
            pend     <= 1'b0;
        end
    end

    // Address of the in-flight request; its data arrives next cycle
    always_ff @(posedge clk) begin
        if (inst_sram_en) pend_pc <= inst_sram_addr;
    end

    if_inst_buf #(
        .DATA_W (IF_ID_BUS_W),
        .DEPTH  (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .flush     (br_taken),
        .push      (push),
        .push_data (pack_if_id(inst_sram_rdata, pend_pc)),
        .pop       (pop),
        .count     (count),
        .head_data (head_data)
    );

    assign stage_1_to_2 = head_data;

endmodule

// File: tb/tb_stage_1_if.sv
// Directed bench for the IF stage with an address-derived SRAM model and a
// program-order scoreboard on every transfer to ID.
module tb_stage_1_if;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata = 32'b0;
    logic        valid_1;
    logic        allow_2;
    logic [63:0] stage_1_to_2;
    logic        br_taken;
    logic [31:0] br_target;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc = 32'h1c000000;

    stage_1_if #(.RESET_PC(32'h1c000000), .BUF_DEPTH(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .valid_1         (valid_1),
        .allow_2         (allow_2),
        .stage_1_to_2    (stage_1_to_2),
        .br_taken        (br_taken),
        .br_target       (br_target)
    );

    always #5 clk = ~clk;

    // SRAM: data is the inverted address, one cycle after an enabled request
    always @(posedge clk) begin
        if (inst_sram_en) inst_sram_rdata <= ~inst_sram_addr;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, act, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge, outputs read 1ns later
    task automatic next(input logic rst, input logic a, input logic br, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        reset     = rst;
        allow_2   = a;
        br_taken  = br;
        br_target = tgt;
        #1;
    endtask

    // Every transfer must be the next program-order pc with matching inst
    always @(negedge clk) begin
        if (reset) begin
            exp_pc = 32'h1c000000;
        end else if (br_taken) begin
            exp_pc = br_target;
        end else if (valid_1 && allow_2) begin
            chk("pop_pc", {32'b0, stage_1_to_2[31:0]}, {32'b0, exp_pc});
            chk("pop_inst", {32'b0, stage_1_to_2[63:32]}, {32'b0, ~exp_pc});
            exp_pc = exp_pc + 32'd4;
        end
    end

    initial begin
        reset = 1'b1; allow_2 = 1'b0; br_taken = 1'b0; br_target = 32'b0;
        repeat (3) next(1, 0, 0, 0);
        chk("rst_valid", {63'b0, valid_1}, 64'd0);
        chk("rst_en", {63'b0, inst_sram_en}, 64'd0);
        chk("rst_bus", stage_1_to_2, 64'd0);
        chk("rst_count", {61'b0, dut.u_buf.count}, 64'd0);
        chk("tie_we", {60'b0, inst_sram_we}, 64'd0);
        chk("tie_wdata", {32'b0, inst_sram_wdata}, 64'd0);

        // Reset release and first fetches
        next(0, 1, 0, 0);                                   // c0
        chk("c0_en", {63'b0, inst_sram_en}, 64'd1);
        chk("c0_addr", {32'b0, inst_sram_addr}, 64'h1c000000);
        chk("c0_valid", {63'b0, valid_1}, 64'd0);
        next(0, 1, 0, 0);                                   // c1
        chk("c1_valid", {63'b0, valid_1}, 64'd0);
        chk("c1_addr", {32'b0, inst_sram_addr}, 64'h1c000004);
        next(0, 1, 0, 0);                                   // c2
        chk("c2_valid", {63'b0, valid_1}, 64'd1);
        chk("c2_bus", stage_1_to_2, {~32'h1c000000, 32'h1c000000});
        next(0, 1, 0, 0);                                   // c3
        chk("c3_pc", {32'b0, stage_1_to_2[31:0]}, 64'h1c000004);

        // ID stall: buffer fills, requests stop, fetch_pc holds
        next(0, 0, 0, 0);                                   // c4
        chk("c4_pc", {32'b0, stage_1_to_2[31:0]}, 64'h1c000008);
        chk("c4_en", {63'b0, inst_sram_en}, 64'd0);
        next(0, 0, 0, 0);                                   // c5
        next(0, 0, 0, 0);                                   // c6
        chk("stall_count", {61'b0, dut.u_buf.count}, 64'd2);
        chk("stall_en", {63'b0, inst_sram_en}, 64'd0);
        chk("stall_addr", {32'b0, inst_sram_addr}, 64'h1c000010);
        chk("stall_valid", {63'b0, valid_1}, 64'd1);
        next(0, 0, 0, 0);                                   // c7
        next(0, 0, 0, 0);                                   // c8
        next(0, 1, 0, 0);                                   // c9
        chk("c9_pc", {32'b0, stage_1_to_2[31:0]}, 64'h1c000008);
        chk("c9_en", {63'b0, inst_sram_en}, 64'd1);
        chk("c9_addr", {32'b0, inst_sram_addr}, 64'h1c000010);
        next(0, 1, 0, 0);                                   // c10
        chk("c10_pc", {32'b0, stage_1_to_2[31:0]}, 64'h1c00000c);
        next(0, 1, 0, 0);                                   // c11
        chk("c11_pc", {32'b0, stage_1_to_2[31:0]}, 64'h1c000010);

        // Redirect while the buffer holds two entries
        next(0, 0, 0, 0);                                   // c12
        next(0, 0, 0, 0);                                   // c13
        next(0, 0, 0, 0);                                   // c14
        chk("full_count", {61'b0, dut.u_buf.count}, 64'd2);
        next(0, 0, 1, 32'h1c000100);                        // c15
        chk("br_valid", {63'b0, valid_1}, 64'd0);
        chk("br_en", {63'b0, inst_sram_en}, 64'd1);
        chk("br_addr", {32'b0, inst_sram_addr}, 64'h1c000100);
        next(0, 0, 0, 0);                                   // c16
        chk("br1_valid", {63'b0, valid_1}, 64'd0);
        chk("br1_count", {61'b0, dut.u_buf.count}, 64'd0);
        next(0, 1, 0, 0);                                   // c17
        chk("br2_valid", {63'b0, valid_1}, 64'd1);
        chk("br2_pc", {32'b0, stage_1_to_2[31:0]}, 64'h1c000100);
        next(0, 1, 0, 0);                                   // c18
        chk("br3_pc", {32'b0, stage_1_to_2[31:0]}, 64'h1c000104);

        // Redirect coinciding with a would-be pop and an arriving response
        next(0, 1, 1, 32'h1c000200);                        // c19
        chk("brp_valid", {63'b0, valid_1}, 64'd0);
        chk("brp_addr", {32'b0, inst_sram_addr}, 64'h1c000200);
        next(0, 1, 0, 0);                                   // c20
        chk("brp_count", {61'b0, dut.u_buf.count}, 64'd0);
        chk("brp1_valid", {63'b0, valid_1}, 64'd0);
        next(0, 1, 0, 0);                                   // c21
        chk("brp2_pc", {32'b0, stage_1_to_2[31:0]}, 64'h1c000200);

        // Reset in the middle of operation with a full buffer
        next(0, 0, 0, 0);                                   // c22
        next(0, 0, 0, 0);                                   // c23
        chk("pre_rst_count", {61'b0, dut.u_buf.count}, 64'd2);
        next(1, 0, 0, 0);                                   // c24
        chk("mid_rst_en", {63'b0, inst_sram_en}, 64'd0);
        next(0, 1, 0, 0);                                   // c25
        chk("post_rst_valid", {63'b0, valid_1}, 64'd0);
        chk("post_rst_count", {61'b0, dut.u_buf.count}, 64'd0);
        chk("post_rst_bus", stage_1_to_2, 64'd0);
        chk("post_rst_addr", {32'b0, inst_sram_addr}, 64'h1c000000);
        next(0, 1, 0, 0);                                   // c26
        chk("post_rst1_valid", {63'b0, valid_1}, 64'd0);
        next(0, 1, 0, 0);                                   // c27
        chk("post_rst2_pc", {32'b0, stage_1_to_2[31:0]}, 64'h1c000000);

        // Random ID back-pressure, no branches
        for (int i = 0; i < 1000; i++) begin
            next(0, 1'($urandom_range(0, 1)), 0, 0);
            chk("count_bound", {63'b0, (dut.u_buf.count <= 2)}, 64'd1);
        end
        next(0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
